// File: rtl/vx_sfu_issue_ctrl_if.sv
// Handshake bundle between dispatch, the SFU issue controller and its sub-units.
// master: dispatch/sub-unit/commit side; slave: the issue controller.
interface vx_sfu_issue_ctrl_if #(
   parameter int unsigned NUM_WARPS = 4,
   parameter int unsigned NUM_UNITS = 2,
   parameter int unsigned DATAW     = 64
);
   localparam int unsigned WID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int unsigned UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   // dispatch request
   logic                 req_valid;
   logic [WID_W-1:0]     req_wid;
   logic [UNIT_W-1:0]    req_unit;
   logic                 req_fence;
   logic [DATAW-1:0]     req_data;
   logic                 req_ready;

   // sub-unit issue
   logic [NUM_UNITS-1:0] unit_valid;
   logic [DATAW-1:0]     unit_data;
   logic [NUM_UNITS-1:0] unit_ready;

   // commit and status
   logic                 cmt_valid;
   logic [WID_W-1:0]     cmt_wid;
   logic [NUM_WARPS-1:0] pending_mask;
   logic                 idle;

   modport master (
      output req_valid, req_wid, req_unit, req_fence, req_data, unit_ready, cmt_valid, cmt_wid,
      input  req_ready, unit_valid, unit_data, pending_mask, idle
   );

   modport slave (
      input  req_valid, req_wid, req_unit, req_fence, req_data, unit_ready, cmt_valid, cmt_wid,
      output req_ready, unit_valid, unit_data, pending_mask, idle
   );
endinterface

// File: rtl/vx_sfu_issue_ctrl.sv
// SFU issue controller: one-entry output buffer to the SFU sub-units, per-warp
// outstanding-op counters and fence tracking.
// Optional macro SFU_ISSUE_PERF_EN adds a saturating 44-bit stall counter output.
module vx_sfu_issue_ctrl #(
   parameter int unsigned NUM_WARPS = 4,
   parameter int unsigned NUM_UNITS = 2,
   parameter int unsigned DATAW     = 64,
   parameter int unsigned CNT_WIDTH = 3
) (
   input  logic               clk,
   input  logic               reset,
`ifdef SFU_ISSUE_PERF_EN
   output logic [43:0]        perf_stalls,
`endif
   vx_sfu_issue_ctrl_if.slave bus
);
   localparam int unsigned WID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int unsigned UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam logic [CNT_WIDTH-1:0] CntMax = '1;
   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

   logic                 buf_valid;
   logic [UNIT_W-1:0]    buf_unit;
   logic [DATAW-1:0]     buf_data;
   logic [CNT_WIDTH-1:0] cnt   [NUM_WARPS];
   logic [CNT_WIDTH-1:0] cnt_d [NUM_WARPS];
   logic [NUM_WARPS-1:0] fence_pend;
   logic [NUM_WARPS-1:0] fence_d;
   logic [NUM_WARPS-1:0] inc;
   logic [NUM_WARPS-1:0] dec;
   logic [NUM_WARPS-1:0] pending;
   logic [CNT_WIDTH-1:0] req_cnt;
   logic                 space;
   logic                 blocked;
   logic                 req_ready;
   logic                 accept;
   logic                 drain;
   logic [31:0]          req_unit_ext;

   assign req_cnt   = cnt[bus.req_wid];
   assign drain     = buf_valid && bus.unit_ready[buf_unit];
   // The buffer can take a new op if empty or if its current op leaves this cycle.
   assign space     = !buf_valid || bus.unit_ready[buf_unit];
   assign blocked   = fence_pend[bus.req_wid] || (req_cnt == CntMax) ||
                      (bus.req_fence && (req_cnt != '0));
   assign req_ready = space && !blocked;
   assign accept    = bus.req_valid && req_ready;

   assign bus.req_ready    = req_ready;
   assign bus.unit_data    = buf_data;
   assign bus.pending_mask = pending;
   assign bus.idle         = (pending == '0) && !buf_valid;

   // Output buffer: load on accept, otherwise clear when the target unit takes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid <= 1'b0;
         buf_unit  <= '0;
         buf_data  <= '0;
      end else if (accept) begin
         buf_valid <= 1'b1;
         buf_unit  <= bus.req_unit;
         buf_data  <= bus.req_data;
      end else if (drain) begin
         buf_valid <= 1'b0;
      end
   end

   // Per-warp increment/decrement strobes; a commit on an empty counter is dropped.
   always_comb begin
      inc = '0;
      dec = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         inc[w] = accept && (bus.req_wid == WID_W'(w));
         dec[w] = bus.cmt_valid && (bus.cmt_wid == WID_W'(w)) && (cnt[w] != '0);
      end
   end

   // Counter and fence next state; simultaneous inc/dec cancel out.
   always_comb begin
      fence_d = fence_pend;
      for (int w = 0; w < NUM_WARPS; w++) begin
         cnt_d[w] = cnt[w];
         if (inc[w] && !dec[w]) begin
            cnt_d[w] = cnt[w] + CntOne;
         end else if (dec[w] && !inc[w]) begin
            cnt_d[w] = cnt[w] - CntOne;
            if (cnt[w] == CntOne) fence_d[w] = 1'b0;
         end
         if (inc[w] && bus.req_fence) fence_d[w] = 1'b1;
      end
   end

   // Counter and fence state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++) cnt[w] <= '0;
         fence_pend <= '0;
      end else begin
         cnt        <= cnt_d;
         fence_pend <= fence_d;
      end
   end

   // Status and one-hot unit valid decode.
   always_comb begin
      pending        = '0;
      bus.unit_valid = '0;
      for (int w = 0; w < NUM_WARPS; w++) pending[w] = (cnt[w] != '0);
      for (int i = 0; i < NUM_UNITS; i++) bus.unit_valid[i] = buf_valid && (buf_unit == UNIT_W'(i));
   end

   assign req_unit_ext = 32'(bus.req_unit);

   // Protocol checks: commit on an idle warp, request to a nonexistent unit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(bus.cmt_valid && (cnt[bus.cmt_wid] == '0)));
         assert (!(bus.req_valid && (req_unit_ext >= NUM_UNITS)));
      end
   end

`ifdef SFU_ISSUE_PERF_EN
   // Saturating count of cycles a valid request is held off.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stalls <= '0;
      end else if (bus.req_valid && !req_ready && (perf_stalls != '1)) begin
         perf_stalls <= perf_stalls + 44'd1;
      end
   end
`endif
endmodule
